// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: PC-select codes and FSM state encodings shared by the hazard controller and the PC mux
package pipeline_hazard_ctrl_pkg;
  localparam logic [1:0] PCSEL_NEXT   = 2'b00;
  localparam logic [1:0] PCSEL_BRANCH = 2'b01;
  localparam logic [1:0] PCSEL_ALU    = 2'b11;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: W-bit counter that increments on inc and sticks at all-ones; async active-high reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_d, count_q;
  always_comb count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage pipeline stall/flush/redirect sequencer (hazard inputs in; pcIn_sel, enables, flushes, dmem_err, perf counters out)
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_memRead,
  input  logic             MEM_brTaken,
  input  logic             MEM_jalr,
  input  logic             MEM_memReq,
  input  logic             dmem_ready,
  output logic [1:0]       pcIn_sel,
  output logic             pc_en,
  output logic             IFID_en,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_flush,
  output logic             back_en,
  output logic             dmem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int TW = $clog2(DMEM_TIMEOUT);
  state_t        state_d, state_q;
  logic [TW-1:0] timer_d, timer_q;
  logic          dmem_err_d, dmem_err_q;
  logic          redirect;
  logic          load_use;
  assign load_use = EX_memRead && EX_rd != 5'd0 &&
                    ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    dmem_err_d  = dmem_err_q;
    pcIn_sel    = PCSEL_NEXT;
    pc_en       = 1'b0;
    IFID_en     = 1'b0;
    back_en     = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    redirect    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (MEM_memReq && !dmem_ready) begin
          state_d = ST_MEM_WAIT;
          timer_d = '0;
        end else if (MEM_jalr || MEM_brTaken) begin
          pcIn_sel = MEM_jalr ? PCSEL_ALU : PCSEL_BRANCH;
          {pc_en, IFID_en, back_en, IFID_flush, IDEX_flush, EXMEM_flush} = 6'b111111;
          redirect = 1'b1;
        end else if (load_use) begin
          IDEX_flush = 1'b1;
          back_en    = 1'b1;
        end else begin
          {pc_en, IFID_en, back_en} = 3'b111;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
          timer_d = '0;
          {pc_en, IFID_en, back_en} = 3'b111;
        end else if (timer_q == TW'(DMEM_TIMEOUT - 1)) begin
          state_d    = ST_ERR;
          dmem_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ERR: ;
      default: state_d = ST_RUN;
    endcase
    // Reset is asynchronous, so the outputs must go quiet immediately rather than at the next edge.
    if (reset) begin
      pcIn_sel = PCSEL_NEXT;
      {pc_en, IFID_en, back_en, IFID_flush, IDEX_flush, EXMEM_flush} = 6'b000000;
      redirect = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= ST_RUN;
      timer_q    <= '0;
      dmem_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      dmem_err_q <= dmem_err_d;
    end
  assign dmem_err = dmem_err_q;
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .reset(reset), .inc(!pc_en), .count(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .reset(reset), .inc(redirect), .count(flush_cnt));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for a default instance and a DMEM_TIMEOUT=4/CNT_W=2 instance
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        ID_use_rs1, ID_use_rs2, EX_memRead, MEM_brTaken, MEM_jalr, MEM_memReq, dmem_ready;
  logic [1:0]  sel_a, sel_b;
  logic        pc_en_a, ifid_en_a, ifid_fl_a, idex_fl_a, exmem_fl_a, back_en_a, err_a;
  logic        pc_en_b, ifid_en_b, ifid_fl_b, idex_fl_b, exmem_fl_b, back_en_b, err_b;
  logic [15:0] stall_a, flush_a;
  logic [1:0]  stall_b, flush_b;
  logic [7:0]  ctl_a, ctl_b;
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  assign ctl_a = {sel_a, pc_en_a, ifid_en_a, back_en_a, ifid_fl_a, idex_fl_a, exmem_fl_a};
  assign ctl_b = {sel_b, pc_en_b, ifid_en_b, back_en_b, ifid_fl_b, idex_fl_b, exmem_fl_b};
  localparam logic [7:0] C_IDLE = 8'h00, C_RUN = 8'h38, C_LU = 8'h0A, C_BR = 8'h7F, C_JALR = 8'hFF;
  pipeline_hazard_ctrl u_dut_a (
    .clk(clk), .reset(reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1),
    .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd), .EX_memRead(EX_memRead), .MEM_brTaken(MEM_brTaken),
    .MEM_jalr(MEM_jalr), .MEM_memReq(MEM_memReq), .dmem_ready(dmem_ready), .pcIn_sel(sel_a),
    .pc_en(pc_en_a), .IFID_en(ifid_en_a), .IFID_flush(ifid_fl_a), .IDEX_flush(idex_fl_a),
    .EXMEM_flush(exmem_fl_a), .back_en(back_en_a), .dmem_err(err_a), .stall_cnt(stall_a),
    .flush_cnt(flush_a));
  pipeline_hazard_ctrl #(.DMEM_TIMEOUT(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1),
    .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd), .EX_memRead(EX_memRead), .MEM_brTaken(MEM_brTaken),
    .MEM_jalr(MEM_jalr), .MEM_memReq(MEM_memReq), .dmem_ready(dmem_ready), .pcIn_sel(sel_b),
    .pc_en(pc_en_b), .IFID_en(ifid_en_b), .IFID_flush(ifid_fl_b), .IDEX_flush(idex_fl_b),
    .EXMEM_flush(exmem_fl_b), .back_en(back_en_b), .dmem_err(err_b), .stall_cnt(stall_b),
    .flush_cnt(flush_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    {ID_rs1, ID_rs2, EX_rd} = '0;
    {ID_use_rs1, ID_use_rs2, EX_memRead, MEM_brTaken, MEM_jalr, MEM_memReq, dmem_ready} = '0;
  endtask
  task automatic hazard(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2);
    EX_memRead = 1'b1; EX_rd = rd; ID_rs1 = rs1; ID_rs2 = rs2; ID_use_rs1 = u1; ID_use_rs2 = u2;
  endtask
  initial begin
    reset = 1'b1;
    idle();
    #2;
    chk("reset_ctl_a", ctl_a, C_IDLE);
    chk("reset_ctl_b", ctl_b, C_IDLE);
    tick(); tick();
    reset = 1'b0;
    #2;
    chk("run_ctl", ctl_a, C_RUN);
    chk("run_stall", stall_a, 0);
    chk("run_flush", flush_a, 0);
    chk("run_err", err_a, 0);
    tick();
    hazard(5, 5, 1, 1, 1);
    #2 chk("lu_rs1", ctl_a, C_LU);
    tick();
    EX_memRead = 1'b0;
    #2 chk("lu_bubble_only_one", ctl_a, C_RUN);
    chk("lu_stall1", stall_a, 1);
    tick();
    hazard(7, 2, 7, 1, 1);
    #2 chk("lu_rs2", ctl_a, C_LU);
    tick();
    EX_memRead = 1'b0;
    #2 chk("lu_stall2", stall_a, 2);
    tick();
    hazard(7, 2, 7, 1, 0);
    #2 chk("lu_rs2_unused", ctl_a, C_RUN);
    tick();
    hazard(0, 0, 0, 1, 1);
    #2 chk("lu_x0", ctl_a, C_RUN);
    tick();
    idle();
    MEM_brTaken = 1'b1;
    #2 chk("br_ctl", ctl_a, C_BR);
    chk("br_flush_before", flush_a, 0);
    tick();
    MEM_jalr = 1'b1;
    #2 chk("br_flush1", flush_a, 1);
    chk("jalr_br_ctl", ctl_a, C_JALR);
    tick();
    MEM_brTaken = 1'b0;
    #2 chk("flush2", flush_a, 2);
    chk("jalr_ctl", ctl_a, C_JALR);
    tick();
    idle();
    MEM_memReq = 1'b1; dmem_ready = 1'b1; MEM_brTaken = 1'b1;
    #2 chk("flush3_a", flush_a, 3);
    chk("flush3_b", flush_b, 3);
    chk("memreq_ready_br", ctl_a, C_BR);
    tick();
    idle();
    MEM_brTaken = 1'b1;
    #2 chk("br5_ctl", ctl_a, C_BR);
    tick();
    idle();
    #2 chk("flush5_a", flush_a, 5);
    chk("flush_sat_b", flush_b, 3);
    MEM_memReq = 1'b1; MEM_jalr = 1'b1;
    #1 chk("memreq_beats_jalr", ctl_a, C_IDLE);
    tick();
    idle();
    dmem_ready = 1'b1;
    #2 chk("wait_ready_advance", ctl_a, C_RUN);
    tick();
    idle();
    #2 chk("no_redirect_on_memreq", flush_a, 5);
    chk("stall3", stall_a, 3);
    MEM_memReq = 1'b1;
    #1 chk("dmem_a", ctl_a, C_IDLE);
    tick();
    hazard(5, 5, 1, 1, 0);
    #2 chk("dmem_w0", ctl_a, C_IDLE);
    tick();
    #2 chk("dmem_w1", ctl_a, C_IDLE);
    tick();
    dmem_ready = 1'b1;
    #2 chk("dmem_ready_adv", ctl_a, C_RUN);
    tick();
    dmem_ready = 1'b0; MEM_memReq = 1'b0;
    #2 chk("dmem_stall6", stall_a, 6);
    chk("lu_after_wait", ctl_a, C_LU);
    tick();
    idle();
    #2 chk("stall7", stall_a, 7);
    MEM_memReq = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      #2 chk("to_wait_ctl", ctl_b, C_IDLE);
      chk("to_wait_err", err_b, 0);
      tick();
    end
    MEM_memReq = 1'b0;
    #2 chk("to_err", err_b, 1);
    chk("to_err_ctl", ctl_b, C_IDLE);
    chk("a_wait_ctl", ctl_a, C_IDLE);
    chk("a_no_err", err_a, 0);
    tick();
    #2 chk("err_sticky", err_b, 1);
    chk("err_frozen", ctl_b, C_IDLE);
    reset = 1'b1;
    #1 chk("mid_rst_ctl", ctl_a, C_IDLE);
    chk("mid_rst_stall", stall_a, 0);
    chk("mid_rst_flush", flush_a, 0);
    chk("mid_rst_err_b", err_b, 0);
    tick();
    reset = 1'b0;
    #2 chk("post_rst_ctl_a", ctl_a, C_RUN);
    chk("post_rst_ctl_b", ctl_b, C_RUN);
    chk("post_rst_err_a", err_a, 0);
    tick();
    #2 chk("post_rst_stall", stall_a, 0);
    chk("post_rst_flush_b", flush_b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
